alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// alu_issue: decodes a MIPS ALU-class instruction into a one-hot ALU op and operands
// behind a single registered valid/ready output stage.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] alu_op,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        chk_ovf,
  output logic        illegal,
  output logic [15:0] issue_cnt
);
  localparam logic [11:0] OP_ADD = 12'h001, OP_SUB = 12'h002, OP_AND = 12'h004, OP_OR = 12'h008;
  localparam logic [11:0] OP_NOR = 12'h010, OP_XOR = 12'h020, OP_SLT = 12'h040, OP_SLTU = 12'h080;
  localparam logic [11:0] OP_SLL = 12'h100, OP_SRL = 12'h200, OP_SRA = 12'h400, OP_LUI = 12'h800;

  logic [5:0]  opc, fn;
  logic [31:0] simm, zimm;
  logic [11:0] dec_op;
  logic [31:0] dec_a, dec_b;
  logic        dec_ovf, dec_ill;
  logic        unused_bits;

  assign opc = instr[31:26];
  assign fn = instr[5:0];
  assign simm = {{16{instr[15]}}, instr[15:0]};
  assign zimm = {16'b0, instr[15:0]};
  assign unused_bits = ^instr[25:16];

  always_comb begin
    dec_op = '0;
    dec_a = rs_val;
    dec_b = rt_val;
    dec_ovf = 1'b0;
    if (opc == 6'h00) begin
      case (fn)
        6'h20, 6'h21: dec_op = OP_ADD;
        6'h22, 6'h23: dec_op = OP_SUB;
        6'h24:        dec_op = OP_AND;
        6'h25:        dec_op = OP_OR;
        6'h26:        dec_op = OP_XOR;
        6'h27:        dec_op = OP_NOR;
        6'h2A:        dec_op = OP_SLT;
        6'h2B:        dec_op = OP_SLTU;
        6'h00, 6'h04: dec_op = OP_SLL;
        6'h02, 6'h06: dec_op = OP_SRL;
        6'h03, 6'h07: dec_op = OP_SRA;
        default:      dec_op = '0;
      endcase
      // constant shifts take the shift amount from shamt instead of rs
      if (!fn[5] && !fn[2]) dec_a = {27'b0, instr[10:6]};
      dec_ovf = fn == 6'h20 || fn == 6'h22;
    end else begin
      case (opc)
        6'h08, 6'h09, 6'h23, 6'h2B: begin dec_op = OP_ADD; dec_b = simm; end
        6'h0A: begin dec_op = OP_SLT;  dec_b = simm; end
        6'h0B: begin dec_op = OP_SLTU; dec_b = simm; end
        6'h0C: begin dec_op = OP_AND;  dec_b = zimm; end
        6'h0D: begin dec_op = OP_OR;   dec_b = zimm; end
        6'h0E: begin dec_op = OP_XOR;  dec_b = zimm; end
        6'h0F: begin dec_op = OP_LUI;  dec_a = '0; dec_b = zimm; end
        6'h04, 6'h05: dec_op = OP_SUB;
        default: dec_op = '0;
      endcase
      dec_ovf = opc == 6'h08;
    end
    dec_ill = dec_op == '0;
    if (dec_ill) begin
      dec_a = '0;
      dec_b = '0;
      dec_ovf = 1'b0;
    end
  end

  logic        out_valid_q, out_valid_d;
  logic [11:0] alu_op_q, alu_op_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic        chk_ovf_q, chk_ovf_d, illegal_q, illegal_d;
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic        accept, fire;

  assign in_ready = rst || !out_valid_q || out_ready;
  assign accept = in_valid && in_ready;
  assign fire = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = accept ? 1'b1 : fire ? 1'b0 : out_valid_q;
    alu_op_d = accept ? dec_op : alu_op_q;
    op_a_d = accept ? dec_a : op_a_q;
    op_b_d = accept ? dec_b : op_b_q;
    chk_ovf_d = accept ? dec_ovf : chk_ovf_q;
    illegal_d = accept ? dec_ill : illegal_q;
    issue_cnt_d = issue_cnt_q + {15'b0, fire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_op_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      chk_ovf_q <= 1'b0;
      illegal_q <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q <= alu_op_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      chk_ovf_q <= chk_ovf_d;
      illegal_q <= illegal_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op = alu_op_q;
  assign op_a = op_a_q;
  assign op_b = op_b_q;
  assign chk_ovf = chk_ovf_q;
  assign illegal = illegal_q;
  assign issue_cnt = issue_cnt_q;
endmodule
